// File: rtl/ps2_scan_if.sv
// rtl/ps2_scan_if.sv - scan code word handshake between the PS/2 sequencer and its consumer
interface ps2_scan_if;
  logic [7:0] code;
  logic       is_break;
  logic       is_ext;
  logic       code_valid;
  logic       code_ready;

  modport master (
    output code,
    output is_break,
    output is_ext,
    output code_valid,
    input  code_ready
  );

  modport slave (
    input  code,
    input  is_break,
    input  is_ext,
    input  code_valid,
    output code_ready
  );
endinterface

// File: rtl/ps2_scan_sequencer.sv
// rtl/ps2_scan_sequencer.sv - receive-only PS/2 frame sequencer with E0/F0 prefix folding
module ps2_scan_sequencer #(
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic          CLOCK_50,
  input  logic          Resetn,
  input  logic          ps2_clk,
  input  logic          ps2_dat,
  ps2_scan_if.master    code_if,
  output logic          frame_err,
  output logic          overrun
);

  localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic                   r_fall;
  logic [1:0]             r_state;
  logic [2:0]             r_bitcnt;
  logic [7:0]             r_shift;
  logic                   r_parity;
  logic [TW-1:0]          r_tcnt;
  logic                   r_frame_err;
  logic                   r_ext_pend;
  logic                   r_brk_pend;
  logic [7:0]             r_code;
  logic                   r_is_break;
  logic                   r_is_ext;
  logic                   r_valid;
  logic                   r_overrun;

  logic w_clk_s;
  logic w_dat_s;
  logic w_byte_done;
  logic w_is_e0;
  logic w_is_f0;
  logic w_publish;
  logic w_timeout;
  logic w_xfer;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

  always_comb begin
    w_byte_done = r_fall && (r_state == ST_STOP) && w_dat_s && (^{r_shift, r_parity});
    w_is_e0     = (r_shift == 8'hE0);
    w_is_f0     = (r_shift == 8'hF0);
    w_publish   = w_byte_done && !w_is_e0 && !w_is_f0;
    w_timeout   = !r_fall && (r_state != ST_IDLE) && (r_tcnt == T_LAST);
    w_xfer      = r_valid && code_if.code_ready;
  end

  // Sync flops reset high (idle bus level) so reset release never looks like a falling edge.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_dat};
      r_clk_prev <= w_clk_s;
      r_fall     <= r_clk_prev & ~w_clk_s;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= ST_IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_tcnt      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (r_fall) begin
        r_tcnt <= '0;
        case (r_state)
          ST_IDLE: begin
            if (!w_dat_s) begin
              r_state  <= ST_DATA;
              r_bitcnt <= '0;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          ST_DATA: begin
            r_shift  <= {w_dat_s, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_parity <= w_dat_s;
            r_state  <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            if (!w_byte_done) r_frame_err <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (r_state != ST_IDLE) begin
        // Timeout drops to IDLE, so the counter parks at T_LAST instead of wrapping.
        if (w_timeout) begin
          r_state     <= ST_IDLE;
          r_frame_err <= 1'b1;
        end else begin
          r_tcnt <= r_tcnt + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      r_code     <= '0;
      r_is_break <= 1'b0;
      r_is_ext   <= 1'b0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_timeout) begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else if (w_byte_done) begin
        if (w_is_e0) begin
          r_ext_pend <= 1'b1;
        end else if (w_is_f0) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end
      end

      // A publish coinciding with a transfer reloads; otherwise a held word wins and the new one is lost.
      if (w_publish) begin
        if (!r_valid || code_if.code_ready) begin
          r_code     <= r_shift;
          r_is_break <= r_brk_pend;
          r_is_ext   <= r_ext_pend;
          r_valid    <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign code_if.code       = r_code;
  assign code_if.is_break   = r_is_break;
  assign code_if.is_ext     = r_is_ext;
  assign code_if.code_valid = r_valid;
  assign frame_err          = r_frame_err;
  assign overrun            = r_overrun;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// tb/tb_ps2_scan_sequencer.sv - directed bench for ps2_scan_sequencer
module tb_ps2_scan_sequencer;
  localparam int TO = 200;
  localparam int SS = 2;
  localparam int HB = 20;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  logic frame_err;
  logic overrun;

  ps2_scan_if sif();

  ps2_scan_sequencer #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)) dut (
    .CLOCK_50  (clk),
    .Resetn    (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .code_if   (sif.master),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  int n_xfer, n_ferr, v_run, v_last_run, f_run, f_last_run, rise_cyc, stop_cyc;
  logic [9:0] last_word;

  always @(negedge clk) begin
    if (sif.code_valid && sif.code_ready) begin
      n_xfer++;
      last_word = {sif.code, sif.is_break, sif.is_ext};
    end
    if (sif.code_valid) begin
      if (v_run == 0) rise_cyc = cyc;
      v_run++;
    end else if (v_run != 0) begin
      v_last_run = v_run;
      v_run      = 0;
    end
    if (frame_err) begin
      if (f_run == 0) n_ferr++;
      f_run++;
    end else if (f_run != 0) begin
      f_last_run = f_run;
      f_run      = 0;
    end
  end

  task automatic clear_mon();
    n_xfer = 0; n_ferr = 0; v_run = 0; v_last_run = 0;
    f_run = 0; f_last_run = 0; rise_cyc = 0; stop_cyc = 0;
    last_word = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b, input bit last, input bit rdy_pulse);
    ps2_dat = b;
    repeat (HB) step();
    ps2_clk = 1'b0;
    if (last) stop_cyc = cyc;
    if (rdy_pulse) begin
      repeat (3) step();
      sif.code_ready = 1'b1;
      step();
      sif.code_ready = 1'b0;
      repeat (HB - 4) step();
    end else begin
      repeat (HB) step();
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit rdy_pulse);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0, 1'b0);
    send_bit((~^b) ^ bad_par, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, rdy_pulse);
    ps2_dat = 1'b1;
    repeat (10) step();
  endtask

  initial begin
    sif.code_ready = 1'b1;
    clear_mon();
    repeat (5) step();
    check("rst_word",  {22'd0, sif.code, sif.is_break, sif.is_ext}, 32'h0);
    check("rst_flags", {29'd0, sif.code_valid, frame_err, overrun}, 32'h0);
    rst_n = 1'b1;
    repeat (5) step();

    clear_mon();
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t1_nxfer",   n_xfer, 1);
    check("t1_word",    last_word, {8'h1C, 1'b0, 1'b0});
    check("t1_vwidth",  v_last_run, 1);
    check("t1_latency", rise_cyc - stop_cyc, SS + 2);
    check("t1_nferr",   n_ferr, 0);

    clear_mon();
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t2_nxfer", n_xfer, 1);
    check("t2_word",  last_word, {8'h1C, 1'b1, 1'b0});

    clear_mon();
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    check("t3_nxfer", n_xfer, 1);
    check("t3_word",  last_word, {8'h75, 1'b1, 1'b1});
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t3_nxfer2", n_xfer, 2);
    check("t3_word2",  last_word, {8'h1C, 1'b0, 1'b0});

    clear_mon();
    send_frame(8'h1C, 1'b1, 1'b0);
    check("t4_nferr",  n_ferr, 1);
    check("t4_fwidth", f_last_run, 1);
    check("t4_nxfer",  n_xfer, 0);
    send_frame(8'h32, 1'b0, 1'b0);
    check("t4_word", last_word, {8'h32, 1'b0, 1'b0});

    clear_mon();
    send_frame(8'hF0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0, 1'b0);
    ps2_dat = 1'b1;
    repeat (TO + 50) step();
    check("t5_nferr_to", n_ferr, 1);
    check("t5_nxfer_to", n_xfer, 0);
    send_frame(8'h32, 1'b0, 1'b0);
    check("t5_word",  last_word, {8'h32, 1'b0, 1'b0});
    check("t5_nxfer", n_xfer, 1);
    check("t5_nferr", n_ferr, 1);

    clear_mon();
    sif.code_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0, 1'b0);
    check("t6_code",    {24'd0, sif.code}, 32'h1C);
    check("t6_valid",   {31'd0, sif.code_valid}, 32'h1);
    check("t6_overrun", {31'd0, overrun}, 32'h1);
    check("t6_nxfer",   n_xfer, 0);

    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    check("t7_rst_word",  {22'd0, sif.code, sif.is_break, sif.is_ext}, 32'h0);
    check("t7_rst_flags", {29'd0, sif.code_valid, frame_err, overrun}, 32'h0);
    ps2_dat = 1'b1;
    repeat (5) step();
    rst_n = 1'b1;
    sif.code_ready = 1'b1;
    repeat (5) step();
    clear_mon();
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t7_word",  last_word, {8'h1C, 1'b0, 1'b0});
    check("t7_nxfer", n_xfer, 1);
    check("t7_nferr", n_ferr, 0);

    clear_mon();
    sif.code_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t8_held", {23'd0, sif.code_valid, sif.code}, {23'd0, 1'b1, 8'h1C});
    send_frame(8'h32, 1'b0, 1'b1);
    check("t8_nxfer",   n_xfer, 1);
    check("t8_xword",   last_word, {8'h1C, 1'b0, 1'b0});
    check("t8_code",    {24'd0, sif.code}, 32'h32);
    check("t8_valid",   {31'd0, sif.code_valid}, 32'h1);
    check("t8_overrun", {31'd0, overrun}, 32'h0);
    sif.code_ready = 1'b1;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
